// File: rtl/freq_clk_gen_if.sv
// Signal bundle between a frequency-programming master and the freq_clk_gen
// square-wave generator.
interface freq_clk_gen_if;
    logic [31:0] freq;
    logic        enable;
    logic        clk_out;
    logic        tick;
    logic [31:0] half_period;
    logic        busy;

    modport master (output freq, enable, input clk_out, tick, half_period, busy);
    modport slave  (input freq, enable, output clk_out, tick, half_period, busy);
endinterface

// File: rtl/freq_clk_gen.sv
// Programmable square-wave generator: half-period = CLK_HZ / (2*freq), found by
// a 32-step restoring divider and swapped in only at toggle boundaries.
module freq_clk_gen #(
    parameter logic [31:0] CLK_HZ = 32'd50_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    freq_clk_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DIV, RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] freq_lat_q, freq_lat_d;
    logic [32:0] dvsr_q, dvsr_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  step_q, step_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] hp_q, hp_d;
    logic [31:0] cnt_q, cnt_d;
    logic        clk_out_q, clk_out_d;
    logic        tick_q, tick_d;

    logic        freq_chg;
    logic        div_done;
    logic        boundary;
    logic [33:0] rem_sh;
    logic [33:0] rem_sub;
    logic        q_bit;
    logic [31:0] quo_nxt;
    logic [31:0] h_val;

    assign freq_chg = (state_q != DIV) && (bus.freq != freq_lat_q);
    assign div_done = (state_q == DIV) && (step_q == 5'd31);

    // One restoring step; the remainder is always below the divisor, so bit 33
    // of the trial subtraction is a clean borrow flag.
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_sub = rem_sh - {1'b0, dvsr_q};
    assign q_bit   = ~rem_sub[33];
    assign quo_nxt = {quo_q[30:0], q_bit};
    assign h_val   = (quo_nxt == '0) ? 32'd1 : quo_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RUN: if (freq_chg) state_d = (bus.freq == '0) ? RUN : DIV;
            DIV:       if (div_done) state_d = RUN;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        freq_lat_d = freq_lat_q;
        dvsr_d     = dvsr_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        step_d     = step_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        hp_d       = hp_q;
        cnt_d      = cnt_q;
        clk_out_d  = clk_out_q;
        boundary   = bus.enable && (hp_q != '0) && (cnt_q == hp_q - 32'd1);

        if (!bus.enable || hp_q == '0) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (boundary) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        if (pend_vld_q && (hp_q == '0 || boundary)) begin
            hp_d       = pend_q;
            pend_vld_d = 1'b0;
            if (pend_q == '0) begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        end

        // New pending values are written after the apply so they are not lost.
        if (freq_chg) begin
            freq_lat_d = bus.freq;
            if (bus.freq == '0) begin
                pend_d     = '0;
                pend_vld_d = 1'b1;
            end else begin
                dvsr_d = {bus.freq, 1'b0};
                rem_d  = '0;
                quo_d  = CLK_HZ;
                step_d = '0;
            end
        end

        if (state_q == DIV) begin
            rem_d  = q_bit ? rem_sub[32:0] : rem_sh[32:0];
            quo_d  = quo_nxt;
            step_d = step_q + 5'd1;
            if (div_done) begin
                pend_d     = h_val;
                pend_vld_d = 1'b1;
            end
        end

        tick_d = clk_out_d & ~clk_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_lat_q <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            step_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            hp_q       <= '0;
            cnt_q      <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            freq_lat_q <= freq_lat_d;
            dvsr_q     <= dvsr_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            step_q     <= step_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            hp_q       <= hp_d;
            cnt_q      <= cnt_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        bus.busy        = (state_q == DIV);
        bus.clk_out     = clk_out_q;
        bus.tick        = tick_q;
        bus.half_period = hp_q;
    end
endmodule

// File: tb/tb_freq_clk_gen.sv
// Directed bench for freq_clk_gen at CLK_HZ = 50 MHz with hand-computed
// half-periods, latencies and tick spacings.
module tb_freq_clk_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    freq_clk_gen_if bus ();

    freq_clk_gen #(.CLK_HZ(32'd50_000_000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for busy to rise, then counts its high cycles; ends on the first low sample.
    task automatic busy_len(output int n);
        int t;
        t = 0;
        n = 0;
        while (!bus.busy && t < 8) begin @(negedge clk); t++; end
        while (bus.busy && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic ticks_until(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.tick && n < 400);
    endtask

    task automatic tick_period(output int p);
        int t;
        t = 0;
        p = 0;
        while (!bus.tick && t < 400) begin @(negedge clk); t++; end
        if (bus.tick) begin
            do begin @(negedge clk); p++; end while (!bus.tick && p < 400);
        end
    endtask

    task automatic wait_hp(input logic [31:0] v);
        int t;
        t = 0;
        while (bus.half_period != v && t < 300) begin @(negedge clk); t++; end
    endtask

    initial begin
        int n;
        int hi;
        logic saw_bad;
        logic c0;

        bus.freq   = 32'd1_000_000;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_clk_out", {31'd0, bus.clk_out}, 0);
        check_val("rst_tick", {31'd0, bus.tick}, 0);
        check_val("rst_hp", bus.half_period, 0);
        check_val("rst_busy", {31'd0, bus.busy}, 0);
        rst_n = 1'b1;

        // 1 MHz from reset
        busy_len(n);
        check_val("busy_len_1m", n, 32);
        check_val("hp_at_busy_fall", bus.half_period, 0);
        ticks_until(n);
        check_val("first_tick_lat", n, 26);
        check_val("hp_1m", bus.half_period, 25);
        @(negedge clk);
        check_val("tick_width", {31'd0, bus.tick}, 0);
        tick_period(n);
        check_val("tick_per_1m", n, 50);

        // change to 2 MHz ten cycles into the high half
        repeat (10) @(negedge clk);
        bus.freq = 32'd2_000_000;
        busy_len(n);
        check_val("busy_len_2m", n, 32);
        check_val("hp_kept_25", bus.half_period, 25);
        ticks_until(n);
        check_val("tick_after_2m", n, 7);
        check_val("hp_2m", bus.half_period, 12);
        tick_period(n);
        check_val("tick_per_2m", n, 24);

        // several changes within one division
        bus.freq = 32'd1_000_000;
        repeat (5) @(negedge clk);
        bus.freq = 32'd3_000_000;
        repeat (5) @(negedge clk);
        bus.freq = 32'd4_000_000;
        check_val("busy_mid_div", {31'd0, bus.busy}, 1);
        n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        check_val("first_div_rest", n, 23);
        busy_len(n);
        check_val("busy_len_4m", n, 32);
        saw_bad = 1'b0;
        n = 0;
        while (bus.half_period != 32'd6 && n < 300) begin
            if (bus.half_period == 32'd8) saw_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check_val("hp_4m", bus.half_period, 6);
        check_val("no_3m_result", {31'd0, saw_bad}, 0);
        tick_period(n);
        check_val("tick_per_4m", n, 12);

        // clamp to 1, then stop
        bus.freq = 32'd30_000_000;
        wait_hp(32'd1);
        check_val("hp_30m", bus.half_period, 1);
        tick_period(n);
        check_val("tick_per_30m", n, 2);
        c0 = bus.clk_out;
        @(negedge clk);
        check_val("toggle_30m", {31'd0, bus.clk_out}, {31'd0, ~c0});
        bus.freq = 32'd0;
        @(negedge clk);
        check_val("no_busy_f0", {31'd0, bus.busy}, 0);
        repeat (4) @(negedge clk);
        check_val("hp_f0", bus.half_period, 0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.clk_out || bus.tick) hi++;
        end
        check_val("quiet_f0", hi, 0);

        // enable gating
        bus.freq = 32'd1_000_000;
        wait_hp(32'd25);
        check_val("hp_restart", bus.half_period, 25);
        tick_period(n);
        check_val("tick_per_restart", n, 50);
        bus.enable = 1'b0;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.clk_out || bus.tick) hi++;
        end
        check_val("quiet_disabled", hi, 0);
        check_val("hp_disabled", bus.half_period, 25);
        bus.enable = 1'b1;
        ticks_until(n);
        check_val("tick_after_enable", n, 25);

        // reset at DIV cycle 10
        bus.freq = 32'd500_000;
        n = 0;
        while (!bus.busy && n < 8) begin @(negedge clk); n++; end
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", {31'd0, bus.busy}, 0);
        check_val("mid_rst_hp", bus.half_period, 0);
        check_val("mid_rst_clk_out", {31'd0, bus.clk_out}, 0);
        check_val("mid_rst_tick", {31'd0, bus.tick}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy_len(n);
        check_val("busy_len_500k", n, 32);
        check_val("no_stale_hp", bus.half_period, 0);
        @(negedge clk);
        check_val("hp_500k", bus.half_period, 50);
        tick_period(n);
        check_val("tick_per_500k", n, 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
